systolic_array_nxn: RTL and testbench

- Parametrised output-stationary NxN systolic matrix multiplier computing C = A(NxK) * B(KxN), with runtime K.
- Generalises the fixed 2x2 array: adds internal input skewing, a control FSM, valid/ready handshakes on input and output, signed accumulation and row-serial result readout.
- Sits between the operand-fetch stage and the result-writeback stage of the accelerator datapath.

---
 rtl/systolic_array_nxn.sv | 210 +++++++++++++++++++++
 tb/tb_systolic_array_nxn.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_nxn.sv
// Output-stationary NxN systolic matrix multiplier: C = A(NxK) * B(KxN).
// Operands arrive one k-beat per handshake (column of A, row of B). Results
// are read out one row of C per output handshake.
module systolic_array_nxn #(
  parameter int unsigned N    = 4,
  parameter int unsigned DW   = 16,
  parameter int unsigned ACCW = 40,
  parameter int unsigned KW   = 8,
  localparam int unsigned RW  = (N > 2) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   a_col,
  input  logic [N*DW-1:0]   b_row,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*ACCW-1:0] out_data,
  output logic [RW-1:0]     out_row,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PW  = 2 * DW;
  localparam int unsigned DCW = $clog2(2 * N);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    OUTPUT
  } state_t;

  state_t         state, state_nxt;
  logic [KW-1:0]  k_reg;
  logic [KW-1:0]  beat_cnt;
  logic [DCW-1:0] drain_cnt;
  logic [RW-1:0]  row_cnt;
  logic           accept;
  logic           clr;
  logic           en;
  logic           row_is_last;

  logic signed [DW-1:0]   a_inj  [N];
  logic signed [DW-1:0]   b_inj  [N];
  logic signed [DW-1:0]   a_skew [N];
  logic signed [DW-1:0]   b_skew [N];
  logic signed [DW-1:0]   a_in   [N][N];
  logic signed [DW-1:0]   b_in   [N][N];
  logic signed [DW-1:0]   a_pipe [N][N-1];
  logic signed [DW-1:0]   b_pipe [N-1][N];
  logic signed [PW-1:0]   prod   [N][N];
  logic signed [ACCW-1:0] acc    [N][N];

  assign row_is_last = (row_cnt == RW'(N - 1));
  assign accept      = in_ready && in_valid;
  assign out_row     = row_cnt;

  // Next-state and handshake outputs, decoded from the registered state only
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    clr       = 1'b0;
    en        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = (k_len != '0) ? LOAD : DRAIN;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        en       = 1'b1;
        if (in_valid && (beat_cnt == k_reg - KW'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        en = 1'b1;
        if (drain_cnt == DCW'(2 * N - 2)) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready && row_is_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy     = (state != IDLE);
    out_last = out_valid && row_is_last;
  end

  // State register, job length, beat/drain/row counters and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_reg     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      row_cnt   <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == OUTPUT) && out_ready && row_is_last;
      if (state == IDLE && start) k_reg <= k_len;
      beat_cnt  <= (state == LOAD) ? beat_cnt + KW'(accept) : '0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DCW'(1) : '0;
      if (state == OUTPUT) begin
        if (out_ready) row_cnt <= row_is_last ? '0 : row_cnt + RW'(1);
      end else begin
        row_cnt <= '0;
      end
    end
  end

  // Accepted beats enter the array; idle cycles inject zeros
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      a_inj[i] = accept ? a_col[i*DW +: DW] : '0;
      b_inj[i] = accept ? b_row[i*DW +: DW] : '0;
    end
  end

  // Skew network: lane g is delayed by g register stages
  for (genvar g = 0; g < N; g++) begin : g_skew
    if (g == 0) begin : g_direct
      assign a_skew[g] = a_inj[g];
      assign b_skew[g] = b_inj[g];
    end else begin : g_delay
      logic signed [DW-1:0] a_sr [g];
      logic signed [DW-1:0] b_sr [g];
      // Shift lane g by one stage per active cycle
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          for (int unsigned s = 0; s < g; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else if (en) begin
          a_sr[0] <= a_inj[g];
          b_sr[0] <= b_inj[g];
          for (int unsigned s = 1; s < g; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end
      assign a_skew[g] = a_sr[g-1];
      assign b_skew[g] = b_sr[g-1];
    end
  end

  // PE operand sources: left/top edge from the skew network, else from neighbour
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      if (gj == 0) begin : g_a_edge
        assign a_in[gi][gj] = a_skew[gi];
      end else begin : g_a_int
        assign a_in[gi][gj] = a_pipe[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in[gi][gj] = b_skew[gj];
      end else begin : g_b_int
        assign b_in[gi][gj] = b_pipe[gi-1][gj];
      end
    end
  end

  // Full-width signed products of each PE
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        prod[i][j] = PW'(a_in[i][j]) * PW'(b_in[i][j]);
      end
    end
  end

  // PE grid: accumulate (wrapping) and forward operands right/down
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) acc[i][j] <= '0;
        for (int unsigned j = 0; j < N - 1; j++) a_pipe[i][j] <= '0;
      end
      for (int unsigned i = 0; i < N - 1; i++) begin
        for (int unsigned j = 0; j < N; j++) b_pipe[i][j] <= '0;
      end
    end else if (en) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) acc[i][j] <= acc[i][j] + ACCW'(prod[i][j]);
        for (int unsigned j = 0; j < N - 1; j++) a_pipe[i][j] <= a_in[i][j];
      end
      for (int unsigned i = 0; i < N - 1; i++) begin
        for (int unsigned j = 0; j < N; j++) b_pipe[i][j] <= b_in[i][j];
      end
    end
  end

  // Present the selected result row only while it is being offered
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int unsigned j = 0; j < N; j++) out_data[j*ACCW +: ACCW] = acc[row_cnt][j];
    end
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Randomized self-checking bench for systolic_array_nxn against a plain
// matrix-product reference model.
module tb_systolic_array_nxn;

  localparam int N    = 2;
  localparam int DW   = 8;
  localparam int ACCW = 16;
  localparam int KW   = 8;
  localparam int RW   = 1;
  localparam int KMAX = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [KW-1:0]     k_len;
  logic              in_valid;
  logic              in_ready;
  logic [N*DW-1:0]   a_col;
  logic [N*DW-1:0]   b_row;
  logic              out_valid;
  logic              out_ready;
  logic [N*ACCW-1:0] out_data;
  logic [RW-1:0]     out_row;
  logic              out_last;
  logic              busy;
  logic              done;

  systolic_array_nxn #(.N(N), .DW(DW), .ACCW(ACCW), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic signed [DW-1:0] ma [N][KMAX];
  logic signed [DW-1:0] mb [KMAX][N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // C[i][j] = sum_k A[i][k]*B[k][j], reduced modulo 2^ACCW
  function automatic logic [ACCW-1:0] model_c(input int i, input int j, input int k);
    longint s = 0;
    for (int kk = 0; kk < k; kk++) s += longint'(ma[i][kk]) * longint'(mb[kk][j]);
    return s[ACCW-1:0];
  endfunction

  task automatic fill_random(input int k);
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < N; i++) begin
        ma[i][kk] = DW'($urandom);
        mb[kk][i] = DW'($urandom);
      end
  endtask

  task automatic fill_const(input int k, input int av, input int bv);
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < N; i++) begin
        ma[i][kk] = DW'(av);
        mb[kk][i] = DW'(bv);
      end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_row"},   out_row,   0);
  endtask

  task automatic check_row(input string tag, input int r, input int k);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_row"},   out_row, r);
    check({tag, "_last"},  out_last, (r == N - 1) ? 1 : 0);
    check({tag, "_busy"},  busy, 1);
    for (int j = 0; j < N; j++) check({tag, "_data"}, out_data[j*ACCW +: ACCW], model_c(r, j, k));
  endtask

  // One complete job: start, feed K beats, wait for results, read N rows
  task automatic run_job(input int k, input int gap_fixed, input int gap_pct,
                         input int stall0, input int stall_max, input bit poke);
    int beat, gap_left, last_acc, waited, guard, ov_cyc, stalls, st;
    k_len = KW'(k);
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
    beat = 0; gap_left = 0; last_acc = 0; guard = 0;
    while (beat < k && guard < 2000) begin
      guard++;
      if (gap_left > 0) begin
        in_valid = 1'b0;
        gap_left--;
      end else begin
        in_valid = ($urandom_range(0, 99) >= gap_pct);
      end
      if (in_valid) begin
        for (int i = 0; i < N; i++) begin
          a_col[i*DW +: DW] = ma[i][beat];
          b_row[i*DW +: DW] = mb[beat][i];
        end
      end else begin
        a_col = (N*DW)'($urandom);
        b_row = (N*DW)'($urandom);
      end
      check("load_in_ready", in_ready, 1);
      if (in_valid && in_ready) begin
        last_acc = cyc;
        beat++;
        gap_left = gap_fixed;
      end
      tick();
    end
    in_valid = 1'b0;
    check("drain_in_ready", in_ready, 0);
    check("drain_busy", busy, 1);
    waited = 0;
    while (!out_valid && waited < 200) begin
      start = poke && (waited == 1);
      k_len = KW'($urandom_range(0, 5));
      tick();
      start = 1'b0;
      waited++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    ov_cyc = cyc;
    check("out_valid_cycle", ov_cyc, last_acc + 2 * N);
    stalls = 0;
    for (int r = 0; r < N; r++) begin
      st = (r == 0) ? stall0 : $urandom_range(0, stall_max);
      out_ready = 1'b0;
      for (int s = 0; s < st; s++) begin
        check_row("stall", r, k);
        start = poke && (s == 0);
        tick();
        start = 1'b0;
        stalls++;
      end
      out_ready = 1'b1;
      check_row("row", r, k);
      tick();
    end
    out_ready = $urandom_range(0, 1);
    check("done_pulse", done, 1);
    check("done_cycle", cyc, ov_cyc + N + stalls);
    check("done_busy", busy, 0);
    check("done_out_valid", out_valid, 0);
    tick();
    check("done_once", done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    a_col = '0; b_row = '0; out_ready = 1'b1;
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic 2x2 product: rows [19,22] and [43,50]
    ma[0][0] = 8'sd1; ma[1][0] = 8'sd3; mb[0][0] = 8'sd5; mb[0][1] = 8'sd6;
    ma[0][1] = 8'sd2; ma[1][1] = 8'sd4; mb[1][0] = 8'sd7; mb[1][1] = 8'sd8;
    run_job(2, 0, 0, 0, 0, 1'b0);
    // Same data with three idle cycles between beats
    run_job(2, 3, 0, 0, 0, 1'b0);

    // Signed products and modulo-2^ACCW wrap
    fill_const(3, -128, -128);
    run_job(3, 0, 0, 0, 0, 1'b0);
    fill_const(4, -1, 1);
    run_job(4, 0, 0, 0, 0, 1'b0);

    // Output backpressure: 5 stalled cycles on row 0, random afterwards
    fill_random(3);
    run_job(3, 0, 0, 5, 3, 1'b0);

    // Reset during LOAD, then a clean job must carry no residue
    fill_random(2);
    k_len = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    a_col = {8'sd100, 8'sd99}; b_row = {8'sd77, 8'sd55};
    tick();
    a_col = {8'sd120, 8'sd110}; b_row = {8'sd90, 8'sd80};
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check_idle_outputs("mid_load_reset");
    run_job(2, 0, 0, 0, 0, 1'b0);

    // start ignored outside IDLE; zero-length job reads out zeros
    fill_random(4);
    run_job(4, 0, 0, 2, 2, 1'b1);
    run_job(0, 0, 0, 1, 1, 1'b1);

    // Randomized jobs with gaps, stalls and stray starts
    for (int t = 0; t < 20; t++) begin
      int k;
      k = $urandom_range(1, 12);
      fill_random(k);
      run_job(k, 0, 30, $urandom_range(0, 3), 3, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
